// File: rtl/fanout_signature.sv
// MISR signature and saturating toggle counter over a fixed window of din samples.
// Results are held with done=1 until the next start request.
module fanout_signature #(
    parameter int                   WIDTH        = 5,
    parameter int                   SIG_WIDTH    = 16,
    parameter logic [SIG_WIDTH-1:0] POLY         = 16'h1021,
    parameter logic [SIG_WIDTH-1:0] SEED         = 16'hFFFF,
    parameter int                   WINDOW       = 256,
    parameter int                   TOGGLE_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WIDTH-1:0]        din,
    output logic                    busy,
    output logic                    done,
    output logic [SIG_WIDTH-1:0]    signature,
    output logic [TOGGLE_WIDTH-1:0] toggles
);

    localparam int CNT_W = $clog2(WINDOW);
    // Extra headroom so the toggle sum cannot overflow before the clamp.
    localparam int SUM_W = TOGGLE_WIDTH + $clog2(WIDTH + 1);
    localparam logic [TOGGLE_WIDTH-1:0] TOG_MAX = {TOGGLE_WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        count;
    logic [WIDTH-1:0]        prev;
    logic [SIG_WIDTH-1:0]    sig_next;
    logic [WIDTH-1:0]        diff;
    logic [SUM_W-1:0]        flips;
    logic [SUM_W-1:0]        tog_sum;
    logic [TOGGLE_WIDTH-1:0] tog_next;
    logic                    last_sample;

    assign last_sample = (count == CNT_W'(WINDOW - 1));
    assign diff        = din ^ prev;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        flips = '0;
        for (int i = 0; i < WIDTH; i++) begin
            flips = flips + SUM_W'(diff[i]);
        end
        sig_next = {signature[SIG_WIDTH-2:0], 1'b0}
                 ^ (signature[SIG_WIDTH-1] ? POLY : '0)
                 ^ SIG_WIDTH'(din);
        tog_sum  = SUM_W'(toggles) + flips;
        tog_next = (tog_sum > SUM_W'(TOG_MAX)) ? TOG_MAX : tog_sum[TOGGLE_WIDTH-1:0];
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            signature <= '0;
            toggles   <= '0;
            prev      <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        signature <= SEED;
                        toggles   <= '0;
                        prev      <= din;
                        count     <= '0;
                    end
                end
                RUN: begin
                    signature <= sig_next;
                    toggles   <= tog_next;
                    prev      <= din;
                    if (last_sample) begin
                        // Counter is held on the final sample so it never wraps in-window.
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fanout_signature.sv
// Scoreboard bench for fanout_signature: stimulus pushes expected results,
// per-instance monitors pop and compare on each rising done.
module tb_fanout_signature;

    typedef struct {
        logic [15:0] sig;
        logic [7:0]  tog;
        bit          chk_sig;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start4 = 1'b0;
    logic        start64 = 1'b0;
    logic [4:0]  din = 5'h00;

    logic        busy4, done4, busy64, done64;
    logic [15:0] sig4, sig64;
    logic [7:0]  tog4, tog64;

    exp_t q4[$];
    exp_t q64[$];

    int n_cmp  = 0;
    int n_fail = 0;

    logic done4_prev  = 1'b0;
    logic done64_prev = 1'b0;

    always #5 clock = ~clock;

    fanout_signature #(.WINDOW(4)) dut4 (
        .clock(clock), .reset(reset), .start(start4), .din(din),
        .busy(busy4), .done(done4), .signature(sig4), .toggles(tog4)
    );

    fanout_signature #(.WINDOW(64)) dut64 (
        .clock(clock), .reset(reset), .start(start64), .din(din),
        .busy(busy64), .done(done64), .signature(sig64), .toggles(tog64)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push4(input logic [15:0] s, input logic [7:0] t);
        exp_t e;
        e.sig = s; e.tog = t; e.chk_sig = 1'b1;
        q4.push_back(e);
    endtask

    // Monitors sample on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (done4 && !done4_prev) begin
            if (q4.size() == 0) begin
                check("dut4_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                if (e.chk_sig) check("dut4_signature", 32'(sig4), 32'(e.sig));
                check("dut4_toggles", 32'(tog4), 32'(e.tog));
            end
        end
        done4_prev <= done4;
    end

    always @(negedge clock) begin
        if (done64 && !done64_prev) begin
            if (q64.size() == 0) begin
                check("dut64_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q64.pop_front();
                if (e.chk_sig) check("dut64_signature", 32'(sig64), 32'(e.sig));
                check("dut64_toggles", 32'(tog64), 32'(e.tog));
            end
        end
        done64_prev <= done64;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise[$];

        // Reset values
        step();
        check("reset_busy", 32'(busy4), 32'd0);
        check("reset_done", 32'(done4), 32'd0);
        check("reset_signature", 32'(sig4), 32'd0);
        check("reset_toggles", 32'(tog4), 32'd0);
        reset = 1'b0;

        // Idle hold
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_busy", 32'(busy4), 32'd0);
            check("idle_done", 32'(done4), 32'd0);
        end

        // Known signature, din=0
        din = 5'h00;
        push4(16'h0E1F, 8'd0);
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        check("known_busy_after_e0", 32'(busy4), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("known_done_latency", 32'(done4), 32'(k == 4));
            check("known_busy", 32'(busy4), 32'(k != 4));
        end
        for (int k = 0; k < 3; k++) begin
            step();
            check("known_done_held", 32'(done4), 32'd1);
            check("known_sig_held", 32'(sig4), 32'h0E1F);
        end

        // Toggle count: 00 at E0, then 1F,00,1F,00
        push4(16'h0ED9, 8'd20);
        din = 5'h00;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        check("toggle_done_falls", 32'(done4), 32'd0);
        din = 5'h1F; step();
        din = 5'h00; step();
        din = 5'h1F; step();
        din = 5'h00; step();
        check("toggle_done", 32'(done4), 32'd1);

        // Start pulsed during RUN is ignored
        push4(16'h0E1F, 8'd0);
        din = 5'h00;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        step();
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        check("run_start_busy", 32'(busy4), 32'd1);
        step();
        step();
        check("run_start_done", 32'(done4), 32'd1);
        check("run_start_busy_low", 32'(busy4), 32'd0);

        // Reset mid-window, asserted between edges
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        step();
        step();
        #2 reset = 1'b1;
        #1;
        check("async_reset_busy", 32'(busy4), 32'd0);
        check("async_reset_done", 32'(done4), 32'd0);
        check("async_reset_signature", 32'(sig4), 32'd0);
        check("async_reset_toggles", 32'(tog4), 32'd0);
        #2 reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check("post_reset_no_done", 32'(done4), 32'd0);
        end
        push4(16'h0E1F, 8'd0);
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("post_reset_window_done", 32'(done4), 32'd1);

        // Back-to-back windows with start held high
        for (int k = 0; k < 4; k++) push4(16'h0E1F, 8'd0);
        start4 = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            step();
            if (done4) rise.push_back(c);
        end
        start4 = 1'b0;
        check("b2b_done_count", 32'(rise.size()), 32'd3);
        if (rise.size() == 3) begin
            check("b2b_period_1", 32'(rise[1] - rise[0]), 32'd5);
            check("b2b_period_2", 32'(rise[2] - rise[1]), 32'd5);
        end
        for (int k = 0; k < 3; k++) step();
        check("b2b_last_done", 32'(done4), 32'd1);

        // Saturation on WINDOW=64: 320 toggles clamp to 255
        begin
            exp_t e;
            e.sig = 16'h0000; e.tog = 8'd255; e.chk_sig = 1'b0;
            q64.push_back(e);
        end
        din = 5'h00;
        start64 = 1'b1;
        step();
        start64 = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            din = (i % 2 == 1) ? 5'h1F : 5'h00;
            step();
            if (i == 50) check("sat_before_clamp", 32'(tog64), 32'd250);
            if (i == 52) check("sat_no_wrap", 32'(tog64), 32'd255);
        end
        check("sat_done", 32'(done64), 32'd1);
        check("sat_busy", 32'(busy64), 32'd0);
        check("sat_toggles", 32'(tog64), 32'd255);

        step();
        step();
        check("q4_drained", 32'(q4.size()), 32'd0);
        check("q64_drained", 32'(q64.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fanout_signature.md
# fanout_signature

Downstream checker for the fanout timing-test stage. It consumes the stage's 5-bit `fanout_test` vector, compresses a fixed window of samples into a MISR signature, and counts bit toggles. Both results are held for readout after the window closes. Results can be compared between pre- and post-layout simulation, so every fanout path is exercised by a sequential endpoint whose result can be observed.

## Interface
Parameters:
- `WIDTH`, 5: width of the sampled input vector; must be ≤ `SIG_WIDTH`.
- `SIG_WIDTH`, 16: MISR signature width.
- `POLY`, 16'h1021: MISR feedback polynomial, `SIG_WIDTH` bits.
- `SEED`, 16'hFFFF: signature value loaded when a window starts.
- `WINDOW`, 256: number of samples per window; must be ≥ 2.
- `TOGGLE_WIDTH`, 8: toggle counter width; the counter saturates.

Ports:
- `clock`, input, 1: the only clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state immediately.
- `start`, input, 1: level-sampled request to begin a window.
- `din`, input, `WIDTH`: sampled vector, driven from `fanout_test`.
- `busy`, output, 1: high while the window is collecting samples.
- `done`, output, 1: high while results are valid and held.
- `signature`, output, `SIG_WIDTH`: MISR result.
- `toggles`, output, `TOGGLE_WIDTH`: saturating count of `din` bit transitions.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE, `start`=1 at an edge: `sig`←`SEED`, sample counter←0, `toggles`←0, `prev`←`din`, go to RUN.
- IDLE, `start`=0: hold; outputs keep their reset or previous values.
- RUN, every edge:
  - `sig`←`{sig[SIG_WIDTH-2:0],1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : 0) ^ zero-extended din`.
  - `toggles`←min(`toggles` + popcount(`din ^ prev`), 2^`TOGGLE_WIDTH`−1). The sum is computed wide enough not to overflow before the clamp.
  - `prev`←`din`; counter increments.
- RUN exit: the edge where counter == `WINDOW`−1 performs the final sample, then moves to DONE. Exactly `WINDOW` samples are taken.
- RUN, `start`: ignored; no restart and no effect on results.
- DONE: `signature` and `toggles` are frozen and `done`=1.
  - `start`=1 restarts exactly as from IDLE; `done` falls at that same edge.
  - `start`=0 holds DONE indefinitely.
- Counter width is clog2(`WINDOW`); the counter never wraps inside a window.
- Outputs:
  - `signature` is `sig`, `toggles` is the toggle counter.
  - `busy`=(state==RUN), `done`=(state==DONE), both registered-state decodes.
  - Intermediate values are visible during RUN but are valid only when `done`=1.

## Timing
- Reset values: `busy`=0, `done`=0, `signature`=0 (not `SEED`), `toggles`=0, state IDLE.
- Reset mid-window: state returns to IDLE at once, all results clear, and no `done` pulse occurs.
- Edge sequence:
  - E0: `start` accepted; `busy`=1 after E0.
  - E1..E`WINDOW`: samples taken.
  - After E`WINDOW`: `busy`=0, `done`=1.
- Latency from start acceptance to `done` is `WINDOW` cycles.
- The first toggle comparison is between `din` at E1 and `din` captured at E0.
- Back-to-back windows: holding `start`=1 restarts at the edge after `done` rises, which gives one DONE cycle per window.
- `din` must be synchronous to `clock`; no internal synchronizer.

## Test plan
- Reset and idle:
  - Assert `reset` asynchronously mid-cycle → all outputs 0 before the next edge.
  - Hold IDLE for 10 cycles with `start`=0 → `busy`=`done`=0.
- Known signature: `WINDOW`=4, `din`=0 constant, pulse `start` → `done`=1 exactly 4 cycles after acceptance, `signature`=16'h0E1F, `toggles`=0.
- Toggle count: `WINDOW`=4, `din`=5'h00 at E0, then 5'h1F, 5'h00, 5'h1F, 5'h00 → `toggles`=20.
- Saturation: `WINDOW`=64, `din` alternating 5'h00/5'h1F → 320 toggles clamp to `toggles`=255 with no wrap.
- Start during RUN: with `WINDOW`=4, `din`=0, pulse `start` at sample 2 → window is not extended and `signature`=16'h0E1F.
- Reset mid-window:
  - Assert `reset` at sample 2 → IDLE, outputs 0, no `done`.
  - A new `start` then gives a full, correct window with `signature`=16'h0E1F.
- Back-to-back: hold `start`=1 continuously → `done` high for 1 cycle every `WINDOW`+1 cycles, with an identical signature each window for identical `din`.
